// File: rtl/mpi_rx_fifo.sv
// Receive-side elastic buffer behind the MPI receiver: captures yumi-qualified words,
// presents them first-word-fall-through to the core, and returns one credit per pop.
module mpi_rx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_yumi,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_cred_ok,
    output logic              core_val,
    output logic [DATA_W-1:0] core_data,
    input  logic              core_rdy,
    output logic              cred_ret,
    output logic [CNT_W-1:0]  occupancy,
    output logic              ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } fifo_op_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  credits;
    logic              full;
    fifo_op_t          op;

    assign full       = (occupancy == CNT_W'(DEPTH));
    assign core_val   = (occupancy != '0);
    assign core_data  = mem[rd_ptr];
    assign rx_cred_ok = (credits != '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    always_comb begin
        op      = '0;
        op.pop  = core_val && core_rdy;
        op.push = rx_yumi && (!full || op.pop);
        op.drop = rx_yumi && full && !op.pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (op.push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (op.push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (op.pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy and credits are kept as separate registers moving in opposite directions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
            credits   <= CNT_W'(DEPTH);
        end else if (op.push && !op.pop) begin
            occupancy <= occupancy + CNT_W'(1);
            credits   <= credits - CNT_W'(1);
        end else if (op.pop && !op.push) begin
            occupancy <= occupancy - CNT_W'(1);
            credits   <= credits + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred_ret <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            cred_ret <= op.pop;
            if (op.drop) ovf_err <= 1'b1;
        end
    end

endmodule
